// File: rtl/j17_sequencer_if.sv
// Control and status bundle between the J17 sequencer and its datapath/program memory.
// The sequencer side uses master; the datapath side (or a bench) uses slave.
interface j17_sequencer_if;
   logic        run;
   logic        step;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [4:0]  alucode;
   logic        flag;
   logic        flag1;
   logic [2:0]  op1;
   logic [20:0] op2;
   logic        imControl;
   logic [4:0]  pcControl;
   logic        writecode;
   logic [1:0]  stackSelect;
   logic        dp_en;
   logic        halted;
   logic        err;
   logic [31:0] retired;

   modport master (
      input  run, step, instr, pc,
      output alucode, flag, flag1, op1, op2, imControl, pcControl, writecode,
             stackSelect, dp_en, halted, err, retired
   );

   modport slave (
      output run, step, instr, pc,
      input  alucode, flag, flag1, op1, op2, imControl, pcControl, writecode,
             stackSelect, dp_en, halted, err, retired
   );
endinterface

// File: rtl/j17_sequencer.sv
// J17 fetch/decode/execute controller: latches the instruction word, decodes it into registered
// datapath controls, and issues one dp_en strobe per instruction (stretched for mul/div/mod).
module j17_sequencer #(
   parameter int PROG_DEPTH    = 38,
   parameter int MULDIV_CYCLES = 4
) (
   input logic             clock,
   input logic             reset,
   j17_sequencer_if.master bus
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, WAIT, EXEC, HALT} state_t;

   localparam int          CW    = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
   localparam logic [31:0] DEPTH = 32'(PROG_DEPTH);

   state_t        state, state_nx;
   logic [31:0]   ir;
   logic [2:0]    step_sync;
   logic          step_rise;
   logic [CW-1:0] wait_cnt;
   logic          wait_done;
   logic [4:0]    opc;
   logic          load_ir, load_ctl, set_err;

   logic [4:0]  d_alu, d_pcc;
   logic        d_wc;
   logic [1:0]  d_stk;

   logic [4:0]  alucode_q, pcControl_q;
   logic        flag_q, flag1_q, imControl_q, writecode_q, err_q;
   logic [2:0]  op1_q;
   logic [20:0] op2_q;
   logic [1:0]  stackSelect_q;
   logic [31:0] retired_q;

   assign opc       = ir[31:27];
   // Two synchroniser flops, the third only remembers the previous level for edge detection.
   assign step_rise = step_sync[1] & ~step_sync[2];
   assign wait_done = (int'(wait_cnt) == MULDIV_CYCLES - 1);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         step_sync <= '0;
         wait_cnt  <= '0;
         ir        <= '0;
         err_q     <= 1'b0;
         retired_q <= '0;
      end else begin
         state     <= state_nx;
         step_sync <= {step_sync[1:0], bus.step};
         wait_cnt  <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
         if (load_ir) ir <= bus.instr;
         if (set_err) err_q <= 1'b1;
         if (state == EXEC) retired_q <= retired_q + 32'd1;
      end
   end

   always_comb begin
      state_nx = state;
      load_ir  = 1'b0;
      load_ctl = 1'b0;
      set_err  = 1'b0;
      case (state)
         IDLE:   if (bus.run || step_rise) state_nx = FETCH;
         FETCH: begin
            if (bus.pc >= DEPTH) begin
               state_nx = HALT;
               set_err  = 1'b1;
            end else begin
               load_ir  = 1'b1;
               state_nx = DECODE;
            end
         end
         DECODE: begin
            load_ctl = 1'b1;
            if (opc == 5'd31) begin
               state_nx = HALT;
            end else if (opc >= 5'd24) begin
               state_nx = HALT;
               set_err  = 1'b1;
            end else if ((opc == 5'd3 || opc == 5'd4 || opc == 5'd5) && MULDIV_CYCLES > 0) begin
               state_nx = WAIT;
            end else begin
               state_nx = EXEC;
            end
         end
         WAIT:   if (wait_done) state_nx = EXEC;
         EXEC:   state_nx = bus.run ? FETCH : IDLE;
         HALT:   state_nx = HALT;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      d_alu = '0;
      d_pcc = '0;
      d_wc  = 1'b0;
      d_stk = '0;
      if (opc == 5'd0)       d_wc  = 1'b1;
      else if (opc <= 5'd11) d_alu = opc;
      else if (opc <= 5'd21) d_pcc = opc - 5'd11;
      else if (opc == 5'd22) d_stk = 2'd1;
      else if (opc == 5'd23) d_stk = 2'd2;
   end

   // Controls only change in DECODE so they stay stable through WAIT/EXEC and idle periods.
   always_ff @(posedge clock) begin
      if (reset) begin
         alucode_q     <= '0;
         pcControl_q   <= '0;
         writecode_q   <= 1'b0;
         stackSelect_q <= '0;
         flag_q        <= 1'b0;
         flag1_q       <= 1'b0;
         imControl_q   <= 1'b0;
         op1_q         <= '0;
         op2_q         <= '0;
      end else if (load_ctl) begin
         alucode_q     <= d_alu;
         pcControl_q   <= d_pcc;
         writecode_q   <= d_wc;
         stackSelect_q <= d_stk;
         flag_q        <= ir[26];
         flag1_q       <= ir[25];
         imControl_q   <= ir[24];
         op1_q         <= ir[23:21];
         op2_q         <= ir[20:0];
      end
   end

   assign bus.alucode     = alucode_q;
   assign bus.pcControl   = pcControl_q;
   assign bus.writecode   = writecode_q;
   assign bus.stackSelect = stackSelect_q;
   assign bus.flag        = flag_q;
   assign bus.flag1       = flag1_q;
   assign bus.imControl   = imControl_q;
   assign bus.op1         = op1_q;
   assign bus.op2         = op2_q;
   assign bus.dp_en       = (state == EXEC) && !reset;
   assign bus.halted      = (state == HALT);
   assign bus.err         = err_q;
   assign bus.retired     = retired_q;
endmodule

// File: tb/tb_j17_sequencer.sv
// Scoreboard bench for j17_sequencer: expected decode pushed at launch, checked on each dp_en.
module tb_j17_sequencer;
   typedef struct packed {
      logic [4:0]  alu;
      logic [4:0]  pcc;
      logic        wc;
      logic [1:0]  stk;
      logic        imc;
      logic [2:0]  op1;
      logic [20:0] op2;
      logic [31:0] ret;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   nchk = 0;
   int   nerr = 0;
   exp_t sb[$];
   int   strobe_cyc[$];
   logic [31:0] exp_ret;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   j17_sequencer_if bus ();
   j17_sequencer #(.PROG_DEPTH(38), .MULDIV_CYCLES(4)) dut (.clock(clk), .reset(reset), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] w, input logic [31:0] r);
      exp_t e;
      logic [4:0] o;
      o     = w[31:27];
      e     = '0;
      e.imc = w[24];
      e.op1 = w[23:21];
      e.op2 = w[20:0];
      e.ret = r;
      if (o == 0) e.wc = 1'b1;
      else if (o >= 1 && o <= 11) e.alu = o;
      else if (o >= 12 && o <= 21) e.pcc = o - 5'd11;
      else if (o == 22) e.stk = 2'd1;
      else if (o == 23) e.stk = 2'd2;
      return e;
   endfunction

   always @(negedge clk) begin
      if (reset === 1'b0 && bus.dp_en === 1'b1) begin
         strobe_cyc.push_back(cyc);
         if (sb.size() == 0) chk("unexpected_dp_en", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("alucode", 32'(bus.alucode), 32'(e.alu));
            chk("pcControl", 32'(bus.pcControl), 32'(e.pcc));
            chk("writecode", 32'(bus.writecode), 32'(e.wc));
            chk("stackSelect", 32'(bus.stackSelect), 32'(e.stk));
            chk("imControl", 32'(bus.imControl), 32'(e.imc));
            chk("op1", 32'(bus.op1), 32'(e.op1));
            chk("op2", 32'(bus.op2), 32'(e.op2));
            chk("retired", bus.retired, e.ret);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_instr(input logic [31:0] w);
      sb.push_back(model(w, exp_ret));
      exp_ret++;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      bus.run  = 1'b0;
      bus.step = 1'b0;
      tick(2);
      sb.delete();
      strobe_cyc.delete();
      exp_ret = '0;
      reset   = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic step_one(input logic [31:0] w);
      bus.instr = w;
      expect_instr(w);
      bus.step = 1'b1;
      tick(3);
      bus.step = 1'b0;
      wait_drain("step_drain", 20);
      tick(3);
   endtask

   function automatic logic [31:0] mk(input logic [4:0] o, input logic im, input logic [2:0] r1,
                                      input logic [20:0] o2);
      return {o, 1'b0, 1'b0, im, r1, o2};
   endfunction

   initial begin
      int t0;
      int n;
      logic [31:0] w;
      bus.instr = '0;
      bus.pc    = '0;
      reset     = 1'b1;
      bus.run   = 1'b0;
      bus.step  = 1'b0;
      tick(2);
      chk("rst_alucode", 32'(bus.alucode), 32'd0);
      chk("rst_dp_en", 32'(bus.dp_en), 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_retired", bus.retired, 32'd0);

      // Free-run ADD: strobe every 3rd cycle, run drop lets the in-flight 4th finish.
      do_reset();
      w = mk(5'd1, 1'b1, 3'd2, 21'd5);
      bus.instr = w;
      repeat (4) expect_instr(w);
      t0 = cyc;
      bus.run = 1'b1;
      n = 0;
      while (strobe_cyc.size() < 3 && n < 30) begin
         tick(1);
         n++;
      end
      bus.run = 1'b0;
      chk("add_three_strobes", 32'(strobe_cyc.size() >= 3), 32'd1);
      wait_drain("add_drain", 20);
      tick(6);
      chk("add_strobe_count", 32'(strobe_cyc.size()), 32'd4);
      if (strobe_cyc.size() >= 3) begin
         chk("add_first_latency", 32'(strobe_cyc[0] - t0), 32'd3);
         chk("add_spacing1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd3);
         chk("add_spacing2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd3);
      end
      chk("add_retired", bus.retired, 32'd4);

      // MUL stretched by the wait count; run dropped mid-instruction.
      do_reset();
      w = mk(5'd3, 1'b0, 3'd1, 21'h100000);
      bus.instr = w;
      expect_instr(w);
      t0 = cyc;
      bus.run = 1'b1;
      tick(4);
      chk("mul_wait_alucode", 32'(bus.alucode), 32'd3);
      chk("mul_wait_dp_en", 32'(bus.dp_en), 32'd0);
      bus.run = 1'b0;
      wait_drain("mul_drain", 20);
      tick(4);
      chk("mul_strobe_count", 32'(strobe_cyc.size()), 32'd1);
      if (strobe_cyc.size() >= 1) chk("mul_latency", 32'(strobe_cyc[0] - t0), 32'd7);
      chk("mul_alucode_held", 32'(bus.alucode), 32'd3);

      // Step held high for 10 cycles launches exactly one instruction.
      do_reset();
      w = mk(5'd2, 1'b0, 3'd4, 21'd9);
      bus.instr = w;
      expect_instr(w);
      bus.step = 1'b1;
      tick(10);
      bus.step = 1'b0;
      wait_drain("step_hold_drain", 20);
      tick(5);
      chk("step_hold_count", 32'(strobe_cyc.size()), 32'd1);
      chk("step_hold_retired", bus.retired, 32'd1);

      step_one(mk(5'd13, 1'b0, 3'd0, 21'h0C0000));
      step_one(mk(5'd22, 1'b0, 3'd5, 21'd0));
      step_one(mk(5'd23, 1'b0, 3'd6, 21'd0));
      step_one(mk(5'd0, 1'b1, 3'd7, 21'h1FFFFF));
      chk("step_retired", bus.retired, 32'd5);

      // HALT opcode: sticky, ignores run/step, cleared only by reset.
      do_reset();
      bus.instr = {5'd31, 27'd0};
      bus.run = 1'b1;
      tick(10);
      chk("halt_halted", 32'(bus.halted), 32'd1);
      chk("halt_err", 32'(bus.err), 32'd0);
      bus.run = 1'b0;
      bus.step = 1'b1;
      tick(3);
      bus.step = 1'b0;
      tick(3);
      bus.run = 1'b1;
      tick(3);
      bus.run = 1'b0;
      tick(2);
      chk("halt_sticky", 32'(bus.halted), 32'd1);
      chk("halt_no_strobe", 32'(strobe_cyc.size()), 32'd0);
      do_reset();
      tick(1);
      chk("halt_reset_clears", 32'(bus.halted), 32'd0);

      // Illegal opcode.
      bus.instr = {5'd26, 27'd0};
      bus.run = 1'b1;
      tick(10);
      bus.run = 1'b0;
      chk("illegal_halted", 32'(bus.halted), 32'd1);
      chk("illegal_err", 32'(bus.err), 32'd1);

      // PC out of range at fetch, and the last legal address.
      do_reset();
      bus.pc = 32'd38;
      bus.instr = mk(5'd1, 1'b0, 3'd1, 21'd1);
      bus.run = 1'b1;
      tick(10);
      bus.run = 1'b0;
      chk("pc_range_halted", 32'(bus.halted), 32'd1);
      chk("pc_range_err", 32'(bus.err), 32'd1);
      chk("pc_range_no_strobe", 32'(strobe_cyc.size()), 32'd0);
      do_reset();
      bus.pc = 32'd37;
      step_one(mk(5'd11, 1'b0, 3'd3, 21'd2));
      chk("pc_last_ok_err", 32'(bus.err), 32'd0);

      // Reset during WAIT aborts the instruction.
      do_reset();
      bus.pc = 32'd0;
      bus.instr = mk(5'd4, 1'b0, 3'd1, 21'd0);
      bus.run = 1'b1;
      tick(4);
      reset = 1'b1;
      bus.run = 1'b0;
      #3;
      chk("abort_dp_en", 32'(bus.dp_en), 32'd0);
      tick(1);
      chk("abort_alucode", 32'(bus.alucode), 32'd0);
      reset = 1'b0;
      tick(10);
      chk("abort_no_strobe", 32'(strobe_cyc.size()), 32'd0);
      chk("abort_retired", bus.retired, 32'd0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
